// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP48A1 operand sequencer.
// Tag kinds steer the slice OPMODE; the cleared kind maps to the P-clearing opcode.
package dsp_pkg;

  localparam logic [7:0] OPM_CLR   = 8'h00;  // X=0, Z=0
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_NEXT  = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P

  typedef enum logic [1:0] {
    KIND_CLR    = 2'd0,
    KIND_FIRST  = 2'd1,
    KIND_NEXT   = 2'd2,
    KIND_BUBBLE = 2'd3
  } tag_kind_e;

  typedef struct packed {
    tag_kind_e kind;
    logic      last;
  } tag_t;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic [7:0] tag_opmode(input tag_kind_e kind);
    case (kind)
      KIND_FIRST:  return OPM_FIRST;
      KIND_NEXT:   return OPM_NEXT;
      KIND_BUBBLE: return OPM_HOLD;
      default:     return OPM_CLR;
    endcase
  endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Fixed-depth shift register of operand tags, aligned so the head tag
// meets the slice OPMODE register on the same edge its product reaches M.
module dsp_tag_pipe
  import dsp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_head
);

  tag_t r_pipe [DEPTH];

  // NOTE: this tiny array is reset on purpose: cleared tags drive OPM_CLR,
  // which is what zeroes P after reset. Large RAM-like arrays should not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_head = r_pipe[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// Operand sequencer driving a DSP48A1-style slice to compute signed dot
// products of streamed (a, b) pairs; returns one 48-bit total per vector.
module dsp_mac_seq
  import dsp_pkg::*;
#(
  parameter int P_LAT = 3,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [17:0]       S_A,
  input  logic [17:0]       S_B,
  input  logic              S_LAST,
  output logic [17:0]       DSP_A,
  output logic [17:0]       DSP_B,
  output logic [17:0]       DSP_D,
  output logic [7:0]        DSP_OPMODE,
  input  logic [47:0]       DSP_P,
  output logic              R_VALID,
  input  logic              R_READY,
  output logic [47:0]       R_DATA,
  output logic [CNT_W-1:0]  R_COUNT
);

  state_e           r_state, w_state_nxt;
  logic             r_started;
  logic             w_accept;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc, r_count;
  logic [17:0]      r_dsp_a, r_dsp_b;
  logic [47:0]      r_data;
  logic [1:0]       r_cap_dly;
  tag_t             w_tag_in, w_head;

  assign w_accept  = S_VALID && S_READY;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // A zero count means no sample of the current vector has been taken yet.
  always_comb begin
    w_tag_in.kind = KIND_BUBBLE;
    w_tag_in.last = 1'b0;
    if (w_accept) begin
      w_tag_in.kind = (r_cnt == '0) ? KIND_FIRST : KIND_NEXT;
      w_tag_in.last = S_LAST;
    end
  end

  dsp_tag_pipe #(.DEPTH(P_LAT - 1)) u_tag_pipe (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_tag  (w_tag_in),
    .o_head (w_head)
  );

  // NOTE: sequential state uses <= only so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_ACC;
    else        r_state <= w_state_nxt;
  end

  // NOTE: defaults first so every path assigns w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:   if (w_accept && S_LAST) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_cap_dly[1])       w_state_nxt = ST_HOLD;
      ST_HOLD:  if (R_READY)            w_state_nxt = ST_ACC;
      default:                          w_state_nxt = ST_ACC;
    endcase
  end

  always_comb begin
    S_READY = r_started && (r_state == ST_ACC);
    R_VALID = (r_state == ST_HOLD);
  end

  // The last tag leaves the head one edge before P holds the total;
  // capture on the edge after that.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_started <= 1'b0;
      r_dsp_a   <= '0;
      r_dsp_b   <= '0;
      r_cnt     <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_cap_dly <= '0;
    end else begin
      r_started <= 1'b1;
      r_dsp_a   <= w_accept ? S_A : '0;
      r_dsp_b   <= w_accept ? S_B : '0;
      r_cap_dly <= {r_cap_dly[0], w_head.last};
      if (w_accept) begin
        if (S_LAST) begin
          r_count <= w_cnt_inc;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= w_cnt_inc;
        end
      end
      if (r_cap_dly[1]) r_data <= DSP_P;
    end
  end

  assign DSP_A      = r_dsp_a;
  assign DSP_B      = r_dsp_b;
  assign DSP_D      = '0;
  assign DSP_OPMODE = tag_opmode(w_head.kind);
  assign R_DATA     = r_data;
  assign R_COUNT    = r_count;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq driving a behavioural DSP48A1 slice
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1, pre-adder bypassed, carry-in 0).
module tb_dsp_mac_seq;

  localparam int P_LAT = 3;
  localparam int CNT_W = 16;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              S_VALID = 1'b0;
  logic              S_READY;
  logic [17:0]       S_A = '0;
  logic [17:0]       S_B = '0;
  logic              S_LAST = 1'b0;
  logic [17:0]       DSP_A, DSP_B, DSP_D;
  logic [7:0]        DSP_OPMODE;
  logic [47:0]       DSP_P;
  logic              R_VALID;
  logic              R_READY = 1'b0;
  logic [47:0]       R_DATA;
  logic [CNT_W-1:0]  R_COUNT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural slice; P starts non-zero so the post-reset clear is visible.
  logic [17:0] s_a1 = '0, s_b1 = '0;
  logic signed [35:0] s_m = '0;
  logic [7:0]  s_opm = '0;
  logic [47:0] s_p = 48'h0000_00AB_CDEF;
  logic [47:0] s_x, s_z;

  always_comb begin
    s_x = (s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
    s_z = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
  end

  always @(posedge CLK) begin
    s_a1  <= DSP_A;
    s_b1  <= DSP_B;
    s_m   <= $signed(s_a1) * $signed(s_b1);
    s_opm <= DSP_OPMODE;
    s_p   <= s_z + s_x;
  end

  assign DSP_P = s_p;

  dsp_mac_seq #(.P_LAT(P_LAT), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .S_VALID    (S_VALID),
    .S_READY    (S_READY),
    .S_A        (S_A),
    .S_B        (S_B),
    .S_LAST     (S_LAST),
    .DSP_A      (DSP_A),
    .DSP_B      (DSP_B),
    .DSP_D      (DSP_D),
    .DSP_OPMODE (DSP_OPMODE),
    .DSP_P      (DSP_P),
    .R_VALID    (R_VALID),
    .R_READY    (R_READY),
    .R_DATA     (R_DATA),
    .R_COUNT    (R_COUNT)
  );

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_sample(input logic [17:0] a, input logic [17:0] b,
                              input logic last, output int acc_cyc);
    int n = 0;
    S_VALID = 1'b1; S_A = a; S_B = b; S_LAST = last;
    while (!S_READY && n < 100) begin @(negedge CLK); n++; end
    n_tests++;
    if (S_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: S_READY=%b required 1", S_READY);
    end
    @(posedge CLK); @(negedge CLK);
    acc_cyc = cyc;
    S_VALID = 1'b0; S_LAST = 1'b0; S_A = '0; S_B = '0;
  endtask

  // Waits (bounded) for R_VALID, samples the result, then completes the handshake.
  task automatic get_result(output logic [47:0] d, output logic [CNT_W-1:0] c,
                            output int rv_cyc, output logic got);
    int n = 0;
    while (!R_VALID && n < 100) begin @(negedge CLK); n++; end
    got = R_VALID; d = R_DATA; c = R_COUNT; rv_cyc = cyc;
    R_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    R_READY = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_tests++; if (S_READY !== 1'b0)      begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", S_READY); end
    n_tests++; if (R_VALID !== 1'b0)      begin n_fail++; $display("FAIL rst_r_valid: got %b want 0", R_VALID); end
    n_tests++; if (R_DATA !== 48'd0)      begin n_fail++; $display("FAIL rst_r_data: got %h want 0", R_DATA); end
    n_tests++; if (R_COUNT !== '0)        begin n_fail++; $display("FAIL rst_r_count: got %0d want 0", R_COUNT); end
    n_tests++; if (DSP_A !== 18'd0 || DSP_B !== 18'd0 || DSP_D !== 18'd0)
      begin n_fail++; $display("FAIL rst_dsp_ab: got A=%h B=%h D=%h want 0", DSP_A, DSP_B, DSP_D); end
    n_tests++; if (DSP_OPMODE !== 8'h00)  begin n_fail++; $display("FAIL rst_opmode: got %h want 00", DSP_OPMODE); end
    RST_N = 1'b1;
    n_tests++; if (S_READY !== 1'b0)      begin n_fail++; $display("FAIL rel_s_ready0: got %b want 0", S_READY); end
    @(negedge CLK);
    n_tests++; if (S_READY !== 1'b1)      begin n_fail++; $display("FAIL rel_s_ready1: got %b want 1", S_READY); end
    n_tests++; if (DSP_OPMODE !== 8'h00)  begin n_fail++; $display("FAIL rel_opmode_clr: got %h want 00", DSP_OPMODE); end
    @(negedge CLK);
    n_tests++; if (DSP_P !== 48'd0)       begin n_fail++; $display("FAIL rel_p_clear: got %h want 0", DSP_P); end
    n_tests++; if (DSP_OPMODE !== 8'h08)  begin n_fail++; $display("FAIL rel_opmode_hold: got %h want 08", DSP_OPMODE); end
  endtask

  task automatic test_dot3();
    int a0, a1, a2, rv; logic [47:0] d; logic [CNT_W-1:0] c; logic got;
    drive_sample(18'd3, 18'd4, 1'b0, a0);
    drive_sample(18'd5, -18'sd6, 1'b0, a1);
    drive_sample(-18'sd7, 18'd8, 1'b1, a2);
    get_result(d, c, rv, got);
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL dot3_valid: got %b want 1", got); end
    // 12 - 30 - 56 = -74
    n_tests++; if (d !== 48'hFFFF_FFFF_FFB6) begin n_fail++; $display("FAIL dot3_data: got %h want ffffffffffb6", d); end
    n_tests++; if (c !== 16'd3) begin n_fail++; $display("FAIL dot3_count: got %0d want 3", c); end
    n_tests++; if (rv - a2 !== 4) begin n_fail++; $display("FAIL dot3_latency: got %0d edges want 4", rv - a2); end
  endtask

  task automatic test_single();
    int a0, rv; logic [47:0] d; logic [CNT_W-1:0] c; logic got;
    drive_sample(-18'sd131072, -18'sd131072, 1'b1, a0);
    get_result(d, c, rv, got);
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", got); end
    n_tests++; if (d !== 48'h0004_0000_0000) begin n_fail++; $display("FAIL single_data: got %h want 000400000000", d); end
    n_tests++; if (c !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", c); end
  endtask

  task automatic test_bubbles();
    int a0, a1, rv; logic [47:0] d; logic [CNT_W-1:0] c; logic got;
    drive_sample(18'd2, 18'd3, 1'b0, a0);
    @(negedge CLK);
    n_tests++; if (DSP_OPMODE !== 8'h01) begin n_fail++; $display("FAIL bub_first: got %h want 01", DSP_OPMODE); end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_tests++; if (DSP_OPMODE !== 8'h08) begin n_fail++; $display("FAIL bub_hold%0d: got %h want 08", i, DSP_OPMODE); end
    end
    drive_sample(18'd4, 18'd5, 1'b1, a1);
    n_tests++; if (DSP_OPMODE !== 8'h08) begin n_fail++; $display("FAIL bub_hold2: got %h want 08", DSP_OPMODE); end
    @(negedge CLK);
    n_tests++; if (DSP_OPMODE !== 8'h09) begin n_fail++; $display("FAIL bub_next: got %h want 09", DSP_OPMODE); end
    get_result(d, c, rv, got);
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL bub_valid: got %b want 1", got); end
    n_tests++; if (d !== 48'd26) begin n_fail++; $display("FAIL bub_data: got %0d want 26", d); end
    n_tests++; if (c !== 16'd2) begin n_fail++; $display("FAIL bub_count: got %0d want 2", c); end
  endtask

  task automatic test_backpressure();
    int a0, n, rv; logic [47:0] d; logic [CNT_W-1:0] c; logic got;
    drive_sample(18'd7, -18'sd3, 1'b1, a0);
    n = 0;
    while (!R_VALID && n < 100) begin @(negedge CLK); n++; end
    n_tests++; if (R_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", R_VALID); end
    S_VALID = 1'b1; S_A = 18'd5; S_B = 18'd5; S_LAST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_tests++;
      if (S_READY !== 1'b0 || R_VALID !== 1'b1 || R_DATA !== 48'hFFFF_FFFF_FFEB
          || R_COUNT !== 16'd1 || DSP_A !== 18'd0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got rdy=%b vld=%b data=%h cnt=%0d dspa=%h want 0 1 ffffffffffeb 1 0",
                 i, S_READY, R_VALID, R_DATA, R_COUNT, DSP_A);
      end
    end
    R_READY = 1'b1;
    n_tests++; if (S_READY !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_pre: got %b want 0", S_READY); end
    @(posedge CLK); @(negedge CLK);
    R_READY = 1'b0;
    n_tests++;
    if (R_VALID !== 1'b0 || S_READY !== 1'b1 || DSP_A !== 18'd0) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b dspa=%h want 0 1 0", R_VALID, S_READY, DSP_A);
    end
    @(posedge CLK); @(negedge CLK);
    S_VALID = 1'b0; S_LAST = 1'b0; S_A = '0; S_B = '0;
    n_tests++;
    if (DSP_A !== 18'd5 || S_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got dspa=%h rdy=%b want 5 0", DSP_A, S_READY);
    end
    get_result(d, c, rv, got);
    n_tests++; if (got !== 1'b1 || d !== 48'd25 || c !== 16'd1) begin
      n_fail++; $display("FAIL bp_next: got vld=%b data=%0d cnt=%0d want 1 25 1", got, d, c);
    end
  endtask

  task automatic test_reset_mid();
    int a0, rv; logic [47:0] d; logic [CNT_W-1:0] c; logic got;
    drive_sample(18'd9, 18'd9, 1'b0, a0);
    drive_sample(18'd9, 18'd9, 1'b0, a0);
    RST_N = 1'b0;
    #1;
    n_tests++;
    if (S_READY !== 1'b0 || DSP_A !== 18'd0 || DSP_OPMODE !== 8'h00 || R_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got rdy=%b dspa=%h opm=%h vld=%b want 0 0 00 0", S_READY, DSP_A, DSP_OPMODE, R_VALID);
    end
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_tests++; if (S_READY !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", S_READY); end
    drive_sample(18'd1, 18'd1, 1'b1, a0);
    get_result(d, c, rv, got);
    n_tests++; if (got !== 1'b1 || d !== 48'd1 || c !== 16'd1) begin
      n_fail++; $display("FAIL mid_next: got vld=%b data=%0d cnt=%0d want 1 1 1", got, d, c);
    end
  endtask

  task automatic test_back_to_back();
    int a0, rv; logic [47:0] d; logic [CNT_W-1:0] c; logic got;
    drive_sample(18'd1, 18'd2, 1'b1, a0);
    get_result(d, c, rv, got);
    n_tests++; if (got !== 1'b1 || d !== 48'd2 || c !== 16'd1) begin
      n_fail++; $display("FAIL b2b_first: got vld=%b data=%0d cnt=%0d want 1 2 1", got, d, c);
    end
    drive_sample(18'd10, 18'd10, 1'b1, a0);
    get_result(d, c, rv, got);
    n_tests++; if (got !== 1'b1 || d !== 48'd100 || c !== 16'd1) begin
      n_fail++; $display("FAIL b2b_second: got vld=%b data=%0d cnt=%0d want 1 100 1", got, d, c);
    end
  endtask

  initial begin
    test_reset();
    test_dot3();
    test_single();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
